// File: rtl/airlock_ctrl.sv
// rtl/airlock_ctrl.sv - airlock chamber controller: doors, pump sequencing, occupancy, sticky fault
module airlock_ctrl #(
  parameter int PRESS_CYCLES   = 5,
  parameter int DEPRESS_CYCLES = 7,
  parameter int CNT_W          = 8,
  parameter int CAPACITY       = 3,
  parameter int OCC_W          = 2
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             outer_req,
  input  logic             inner_req,
  input  logic             press_go,
  input  logic             depress_go,
  input  logic             sub_enter,
  input  logic             sub_exit,
  input  logic             err_clr,
  output logic             outer_open,
  output logic             inner_open,
  output logic             pressurized,
  output logic             pumping,
  output logic [OCC_W-1:0] occ,
  output logic             full,
  output logic             err
);

  typedef enum logic [1:0] {S_LOW, S_PRESS, S_HIGH, S_DEPRESS} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic doors_closed;
  logic door_open;
  logic press_acc;
  logic depress_acc;
  logic fault;
  logic occ_inc;
  logic occ_dec;

  // Command acceptance, occupancy moves and fault detection for this cycle
  always_comb begin
    doors_closed = ~outer_open & ~inner_open;
    door_open    = ~doors_closed;
    // A simultaneous press/depress pair is ambiguous, so neither is accepted
    press_acc    = press_go & ~depress_go & (state == S_LOW) & doors_closed;
    depress_acc  = depress_go & ~press_go & (state == S_HIGH) & doors_closed;
    occ_inc      = door_open & sub_enter & ~sub_exit & (occ != OCC_W'(CAPACITY));
    occ_dec      = door_open & sub_exit & ~sub_enter & (occ != '0);
    fault        = (press_go & ~press_acc)
                 | (depress_go & ~depress_acc)
                 | ((sub_enter | sub_exit) & doors_closed)
                 | (door_open & sub_enter & ~sub_exit & full)
                 | (door_open & sub_exit & ~sub_enter & (occ == '0));
  end

  assign full = (occ == OCC_W'(CAPACITY));

  // Pressure state machine with registered door, pump and status outputs
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_LOW;
      cnt         <= '0;
      outer_open  <= 1'b0;
      inner_open  <= 1'b0;
      pressurized <= 1'b0;
      pumping     <= 1'b0;
      occ         <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        S_LOW: begin
          if (press_acc) begin
            state   <= S_PRESS;
            cnt     <= CNT_W'(PRESS_CYCLES - 1);
            pumping <= 1'b1;
          end
        end
        S_PRESS: begin
          if (cnt == '0) begin
            state       <= S_HIGH;
            pumping     <= 1'b0;
            pressurized <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HIGH: begin
          if (depress_acc) begin
            state       <= S_DEPRESS;
            cnt         <= CNT_W'(DEPRESS_CYCLES - 1);
            pumping     <= 1'b1;
            pressurized <= 1'b0;
          end
        end
        default: begin
          if (cnt == '0) begin
            state   <= S_LOW;
            pumping <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase

      // Doors only open in their idle pressure state with the other door shut;
      // a pump start in the same cycle wins over the open request
      outer_open <= outer_req & (state == S_LOW) & ~inner_open & ~press_acc;
      inner_open <= inner_req & (state == S_HIGH) & ~outer_open & ~depress_acc;

      if (occ_inc) begin
        occ <= occ + 1'b1;
      end else if (occ_dec) begin
        occ <= occ - 1'b1;
      end

      // A new fault outranks a same-cycle clear
      if (fault) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_airlock_ctrl.sv
// tb/tb_airlock_ctrl.sv - directed scoreboard bench for airlock_ctrl
module tb_airlock_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic       outer_req, inner_req;
  logic       press_go, depress_go, sub_enter, sub_exit, err_clr;
  logic       outer_open, inner_open, pressurized, pumping, full, err;
  logic [1:0] occ;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  airlock_ctrl #(
    .PRESS_CYCLES(5), .DEPRESS_CYCLES(7), .CNT_W(8), .CAPACITY(3), .OCC_W(2)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n),
    .outer_req(outer_req), .inner_req(inner_req),
    .press_go(press_go), .depress_go(depress_go),
    .sub_enter(sub_enter), .sub_exit(sub_exit), .err_clr(err_clr),
    .outer_open(outer_open), .inner_open(inner_open),
    .pressurized(pressurized), .pumping(pumping),
    .occ(occ), .full(full), .err(err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [7:0] v(input logic oo, input logic io, input logic pr,
                                   input logic pm, input logic [1:0] oc,
                                   input logic fu, input logic er);
    return {oo, io, pr, pm, oc, fu, er};
  endfunction

  task automatic compare_head();
    logic [7:0] obs;
    logic [7:0] expv;
    string      tag;
    obs  = {outer_open, inner_open, pressurized, pumping, occ, full, err};
    expv = exp_q.pop_front();
    tag  = tag_q.pop_front();
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b (oo io pr pm occ full err)", tag, obs, expv);
    end
  endtask

  // Push the expectation, clock once, drop the pulses, then compare at the falling edge
  task automatic step(input string tag, input logic [7:0] expv);
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge CLOCK_50);
    #1;
    press_go = 0; depress_go = 0; sub_enter = 0; sub_exit = 0; err_clr = 0;
    @(negedge CLOCK_50);
    compare_head();
  endtask

  task automatic check_now(input string tag, input logic [7:0] expv);
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    #1;
    compare_head();
  endtask

  initial begin
    reset_n = 0; outer_req = 0; inner_req = 0;
    press_go = 0; depress_go = 0; sub_enter = 0; sub_exit = 0; err_clr = 0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check_now("reset", v(0,0,0,0,2'd0,0,0));
    reset_n = 1;

    // Outer door follows its request in S_LOW
    outer_req = 1;  step("outer_open", v(1,0,0,0,2'd0,0,0));
    outer_req = 0;  step("outer_close", v(0,0,0,0,2'd0,0,0));

    // Pressurize: five pump cycles then station pressure
    press_go = 1;   step("press_p1", v(0,0,0,1,2'd0,0,0));
    for (int i = 2; i <= 5; i++) step("press_pump", v(0,0,0,1,2'd0,0,0));
    step("press_done", v(0,0,1,0,2'd0,0,0));
    inner_req = 1; outer_req = 1;
    step("inner_open", v(0,1,1,0,2'd0,0,0));
    step("outer_blocked", v(0,1,1,0,2'd0,0,0));

    // Occupancy up to capacity, overflow fault, simultaneous pulses
    sub_enter = 1;  step("enter1", v(0,1,1,0,2'd1,0,0));
    sub_enter = 1;  step("enter2", v(0,1,1,0,2'd2,0,0));
    sub_enter = 1;  step("enter3_full", v(0,1,1,0,2'd3,1,0));
    sub_enter = 1;  step("enter4_overflow", v(0,1,1,0,2'd3,1,1));
    sub_enter = 1; sub_exit = 1; step("enter_exit_both", v(0,1,1,0,2'd3,1,1));
    err_clr = 1;    step("err_clr1", v(0,1,1,0,2'd3,1,0));
    inner_req = 0; outer_req = 0;
    step("inner_close", v(0,0,1,0,2'd3,1,0));

    // Conflicting pump commands are both rejected, then depressurize
    depress_go = 1; press_go = 1; step("both_go_reject", v(0,0,1,0,2'd3,1,1));
    err_clr = 1;    step("err_clr2", v(0,0,1,0,2'd3,1,0));
    depress_go = 1; step("depress_p1", v(0,0,0,1,2'd3,1,0));
    for (int i = 2; i <= 7; i++) step("depress_pump", v(0,0,0,1,2'd3,1,0));
    step("depress_done", v(0,0,0,0,2'd3,1,0));

    // Press with a door open is rejected; fault beats same-cycle clear
    outer_req = 1;  step("outer_open2", v(1,0,0,0,2'd3,1,0));
    press_go = 1;   step("press_door_open", v(1,0,0,0,2'd3,1,1));
    err_clr = 1;    step("err_clr3", v(1,0,0,0,2'd3,1,0));
    err_clr = 1; press_go = 1; step("clr_vs_fault", v(1,0,0,0,2'd3,1,1));
    err_clr = 1;    step("err_clr4", v(1,0,0,0,2'd3,1,0));
    sub_exit = 1;   step("exit_one", v(1,0,0,0,2'd2,0,0));
    outer_req = 0;  step("outer_close2", v(0,0,0,0,2'd2,0,0));
    sub_exit = 1;   step("exit_doors_closed", v(0,0,0,0,2'd2,0,1));
    err_clr = 1;    step("err_clr5", v(0,0,0,0,2'd2,0,0));

    // Asynchronous reset in the middle of pressurizing
    press_go = 1;   step("press2_p1", v(0,0,0,1,2'd2,0,0));
    step("press2_p2", v(0,0,0,1,2'd2,0,0));
    step("press2_p3", v(0,0,0,1,2'd2,0,0));
    reset_n = 0;
    check_now("async_reset", v(0,0,0,0,2'd0,0,0));
    @(negedge CLOCK_50);
    reset_n = 1; outer_req = 1;
    step("post_reset_low", v(1,0,0,0,2'd0,0,0));
    outer_req = 0;
    step("post_reset_close", v(0,0,0,0,2'd0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
